// File: rtl/score_rank_sorter_if.sv
// score_rank_sorter_if: pair input, ranked-index output stream and error pulses of the rank sorter
interface score_rank_sorter_if;
    logic [7:0] i_index;
    logic [7:0] i_score;
    logic       i_rvalid;
    logic [7:0] o_index;
    logic [7:0] o_rank;
    logic       o_tvalid;
    logic       o_tlast;
    logic       i_tready;
    logic       o_overflow;
    logic       o_err_dup;
    modport master (
        output i_index, i_score, i_rvalid, i_tready,
        input  o_index, o_rank, o_tvalid, o_tlast, o_overflow, o_err_dup
    );
    modport slave (
        input  i_index, i_score, i_rvalid, i_tready,
        output o_index, o_rank, o_tvalid, o_tlast, o_overflow, o_err_dup
    );
endinterface

// File: rtl/score_rank_sorter.sv
// score_rank_sorter: writes (index, score) pairs into rank-addressed ping-pong tables and streams the TOPK best ranks
module score_rank_sorter #(
    parameter int COL  = 16,
    parameter int TOPK = 4
) (
    input logic i_clk,
    input logic i_reset,
    score_rank_sorter_if.slave bus
);
    localparam int AW = $clog2(COL);
    localparam logic [7:0] COL8 = 8'(COL);
    localparam logic [7:0] LAST_CNT = 8'(COL - 1);
    localparam logic [7:0] LAST_RANK = 8'(TOPK - 1);
    localparam logic [7:0] TOPK8 = 8'(TOPK);

    typedef enum logic [1:0] {FREE, FILL, FULL, READ} bank_t;
    typedef enum logic {IDLE, SEND} rd_t;

    bank_t st [2];
    logic [7:0] tbl [2][COL];
    logic [COL-1:0] mask [2];
    logic [7:0] wr_cnt;
    logic wr_bank, acc, last_full;
    rd_t state, state_n;
    logic rd_bank, rd_bank_n;
    logic [7:0] nr, nr_n;
    logic issue, iss_bank;
    logic [7:0] iss_rank;

    logic first, bank_free, acc_now, wr_en, in_rng, last_pair, dup;
    logic [AW-1:0] sidx;
    assign first = wr_cnt == 8'd0;
    assign bank_free = st[wr_bank] == FREE;
    assign acc_now = first ? bank_free : acc;
    assign wr_en = bus.i_rvalid && acc_now;
    assign in_rng = bus.i_score < COL8;
    assign sidx = bus.i_score[AW-1:0];
    assign last_pair = bus.i_rvalid && wr_cnt == LAST_CNT;
    assign dup = !first && mask[wr_bank][sidx];

    logic load, done, full0, full1, sb, start, more;
    assign load = !bus.o_tvalid || bus.i_tready;
    assign done = bus.o_tvalid && bus.o_tlast && bus.i_tready;
    assign full0 = st[0] == FULL;
    assign full1 = st[1] == FULL;
    // Normally banks complete alternately; last_full only breaks the tie if both are waiting.
    assign sb = (full0 && full1) ? !last_full : full1;
    assign start = load && (full0 || full1) && (state == IDLE || done);
    assign more = load && state == SEND && nr < TOPK8;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st <= '{FREE, FREE};
            wr_cnt <= 8'd0;
            wr_bank <= 1'b0;
            acc <= 1'b0;
            last_full <= 1'b0;
        end else begin
            if (bus.i_rvalid) wr_cnt <= last_pair ? 8'd0 : wr_cnt + 8'd1;
            if (bus.i_rvalid && first) acc <= bank_free;
            if (last_pair) wr_bank <= !wr_bank;
            for (int b = 0; b < 2; b++) begin
                if (wr_en && first && wr_bank == 1'(b)) st[b] <= FILL;
                if (wr_en && last_pair && wr_bank == 1'(b)) begin
                    st[b] <= FULL;
                    last_full <= 1'(b);
                end
                if (start && sb == 1'(b)) st[b] <= READ;
                if (done && rd_bank == 1'(b)) st[b] <= FREE;
            end
        end
    end

    // The first accepted pair wipes the bank, then its own write lands on top.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            if (first) begin
                for (int j = 0; j < COL; j++) tbl[wr_bank][j] <= 8'hFF;
                mask[wr_bank] <= '0;
            end
            if (in_rng) begin
                tbl[wr_bank][sidx] <= bus.i_index;
                mask[wr_bank][sidx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            rd_bank <= 1'b0;
            nr <= 8'd0;
        end else begin
            state <= state_n;
            rd_bank <= rd_bank_n;
            nr <= nr_n;
        end
    end

    always_comb begin
        state_n = start ? SEND : (done ? IDLE : state);
        rd_bank_n = start ? sb : rd_bank;
        nr_n = start ? 8'd1 : (more ? nr + 8'd1 : nr);
    end

    always_comb begin
        issue = start || more;
        iss_bank = start ? sb : rd_bank;
        iss_rank = start ? 8'd0 : nr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_index <= 8'd0;
            bus.o_rank <= 8'd0;
            bus.o_tvalid <= 1'b0;
            bus.o_tlast <= 1'b0;
            bus.o_overflow <= 1'b0;
            bus.o_err_dup <= 1'b0;
        end else begin
            if (load) bus.o_tvalid <= issue;
            if (load && issue) begin
                bus.o_index <= tbl[iss_bank][iss_rank[AW-1:0]];
                bus.o_rank <= iss_rank;
                bus.o_tlast <= iss_rank == LAST_RANK;
            end
            bus.o_overflow <= bus.i_rvalid && first && !bank_free;
            bus.o_err_dup <= wr_en && (!in_rng || dup);
        end
    end
endmodule

// File: tb/tb_score_rank_sorter.sv
// tb_score_rank_sorter: directed and random frames checked against a frame-level bank/queue model
module tb_score_rank_sorter;
    localparam int COL = 16;
    localparam int TOPK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_rank_sorter_if ifc();
    score_rank_sorter #(.COL(COL), .TOPK(TOPK)) dut (.i_clk(clk), .i_reset(rst), .bus(ifc));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int cnt, wb, cyc;
    bit busy [2];
    bit acc;
    logic [7:0] ftab [COL];
    bit fmask [COL];
    bit exp_ovf, exp_err;
    logic [7:0] q_idx [$];
    int q_rank [$];
    int q_bank [$];
    logic [7:0] got [$];
    bit rdy_rand;
    logic rdy_val;
    bit prev_stall;
    logic [7:0] prev_idx, prev_rank;
    int ovf_seen, dup_seen, beats, rank1_cycles;
    int last_pair_cyc, first_beat_cyc, tlast_cyc;

    task automatic model_reset();
        cnt = 0;
        wb = 0;
        busy[0] = 0;
        busy[1] = 0;
        acc = 0;
        exp_ovf = 0;
        exp_err = 0;
        prev_stall = 0;
        q_idx.delete();
        q_rank.delete();
        q_bank.delete();
    endtask

    // Called mid-cycle: checks this cycle's outputs, then advances the model by this cycle's inputs.
    task automatic observe();
        int fb;
        logic [7:0] ei;
        int er, eb;
        fb = -1;
        check("overflow", ifc.o_overflow, exp_ovf);
        check("err_dup", ifc.o_err_dup, exp_err);
        ovf_seen += int'(ifc.o_overflow);
        dup_seen += int'(ifc.o_err_dup);
        if (ifc.o_tvalid && ifc.o_rank == 8'd1) rank1_cycles++;
        if (prev_stall) begin
            check("hold_valid", ifc.o_tvalid, 1);
            check("hold_index", ifc.o_index, prev_idx);
            check("hold_rank", ifc.o_rank, prev_rank);
        end
        if (ifc.o_tvalid && ifc.i_tready) begin
            if (q_idx.size() == 0) check("spurious_beat", ifc.o_tvalid, 0);
            else begin
                ei = q_idx.pop_front();
                er = q_rank.pop_front();
                eb = q_bank.pop_front();
                check("beat_index", ifc.o_index, ei);
                check("beat_rank", ifc.o_rank, er);
                check("beat_tlast", ifc.o_tlast, er == TOPK - 1);
                if (er == 0) first_beat_cyc = cyc;
                if (er == TOPK - 1) begin
                    tlast_cyc = cyc;
                    fb = eb;
                end
                got.push_back(ifc.o_index);
                beats++;
            end
        end
        exp_ovf = 0;
        exp_err = 0;
        if (ifc.i_rvalid) begin
            if (cnt == 0) begin
                acc = !busy[wb];
                exp_ovf = !acc;
                if (acc) begin
                    busy[wb] = 1;
                    for (int j = 0; j < COL; j++) begin
                        ftab[j] = 8'hFF;
                        fmask[j] = 0;
                    end
                end
            end
            if (acc) begin
                if (int'(ifc.i_score) >= COL) exp_err = 1;
                else begin
                    exp_err = fmask[ifc.i_score];
                    ftab[ifc.i_score] = ifc.i_index;
                    fmask[ifc.i_score] = 1;
                end
            end
            cnt++;
            if (cnt == COL) begin
                cnt = 0;
                last_pair_cyc = cyc;
                if (acc) begin
                    for (int r = 0; r < TOPK; r++) begin
                        q_idx.push_back(ftab[r]);
                        q_rank.push_back(r);
                        q_bank.push_back(wb);
                    end
                end
                wb ^= 1;
            end
        end
        if (fb >= 0) busy[fb] = 0;
        prev_stall = ifc.o_tvalid && !ifc.i_tready;
        prev_idx = ifc.o_index;
        prev_rank = ifc.o_rank;
    endtask

    task automatic step(input logic v, input logic [7:0] idx, input logic [7:0] sc);
        ifc.i_rvalid = v;
        ifc.i_index = idx;
        ifc.i_score = sc;
        ifc.i_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'd0, 8'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q_idx.size() > 0 || ifc.o_tvalid) && k < 500) begin
            step(1'b0, 8'd0, 8'd0);
            k++;
        end
        check("drain_empty", q_idx.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.i_rvalid = 1'b0;
        ifc.i_index = 8'd0;
        ifc.i_score = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_outputs_zero", {ifc.o_index, ifc.o_rank, ifc.o_tvalid, ifc.o_tlast, ifc.o_overflow, ifc.o_err_dup}, 0);
        @(posedge clk);
        #1;
    endtask

    // kind 0: index k/score COL-1-k, 1: duplicate + out-of-range, 2: random permutation, 3: permutation with possible fault
    task automatic send_frame(input int kind, input bit gaps);
        logic [7:0] ix [COL];
        logic [7:0] sx [COL];
        logic [7:0] t;
        int j;
        for (int k = 0; k < COL; k++) begin
            ix[k] = 8'(k);
            sx[k] = (kind == 0) ? 8'(COL - 1 - k) : 8'(k);
        end
        if (kind == 1) begin
            ix[0] = 8'd3; sx[0] = 8'd0;
            ix[1] = 8'd7; sx[1] = 8'd0;
            ix[2] = 8'd9; sx[2] = 8'd20;
        end
        if (kind >= 2) begin
            for (int k = COL - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                t = sx[k];
                sx[k] = sx[j];
                sx[j] = t;
            end
            for (int k = 0; k < COL; k++) ix[k] = 8'($urandom_range(0, 255));
            if (kind == 3 && $urandom_range(0, 2) == 0) sx[$urandom_range(0, COL - 1)] = 8'($urandom_range(0, COL + 8));
        end
        for (int k = 0; k < COL; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 8'd0, 8'd0);
            step(1'b1, ix[k], sx[k]);
        end
    endtask

    initial begin
        int k;
        ifc.i_rvalid = 1'b0;
        ifc.i_index = 8'd0;
        ifc.i_score = 8'd0;
        ifc.i_tready = 1'b1;
        rdy_rand = 0;
        rdy_val = 1'b1;
        cyc = 0;
        beats = 0;
        ovf_seen = 0;
        dup_seen = 0;
        rank1_cycles = 0;
        @(posedge clk);
        #1;
        do_reset();

        send_frame(0, 0);
        drain();
        check("basic_first_beat_latency", first_beat_cyc - last_pair_cyc, 2);
        check("basic_tlast_latency", tlast_cyc - last_pair_cyc, TOPK + 1);
        check("basic_beats", got.size(), TOPK);
        check("basic_rank0_index", got[0], COL - 1);
        check("basic_rank3_index", got[3], COL - 4);
        check("basic_no_dup", dup_seen, 0);
        check("basic_no_overflow", ovf_seen, 0);

        got.delete();
        rank1_cycles = 0;
        rdy_val = 1'b0;
        send_frame(0, 0);
        idle(3);
        rdy_val = 1'b1;
        idle(1);
        rdy_val = 1'b0;
        idle(3);
        rdy_val = 1'b1;
        drain();
        check("bp_rank1_visible_cycles", rank1_cycles, 4);
        check("bp_beats", got.size(), TOPK);
        check("bp_rank1_index", got[1], COL - 2);

        got.delete();
        ovf_seen = 0;
        rdy_val = 1'b0;
        repeat (3) send_frame(2, 0);
        idle(2);
        check("pp_overflow_pulses", ovf_seen, 1);
        rdy_val = 1'b1;
        drain();
        check("pp_beats", got.size(), 2 * TOPK);

        got.delete();
        dup_seen = 0;
        send_frame(1, 0);
        drain();
        check("dup_pulses", dup_seen, 2);
        check("dup_rank0_last_wins", got[0], 7);
        check("dup_rank1_unwritten", got[1], 8'hFF);
        check("dup_rank2_unwritten", got[2], 8'hFF);
        check("dup_rank3_index", got[3], 3);

        beats = 0;
        send_frame(0, 0);
        k = 0;
        while (beats < 2 && k < 50) begin
            step(1'b0, 8'd0, 8'd0);
            k++;
        end
        check("rst_two_beats_seen", beats, 2);
        do_reset();
        got.delete();
        send_frame(2, 1);
        drain();
        check("post_reset_beats", got.size(), TOPK);

        rdy_rand = 1;
        repeat (40) send_frame(3, 1);
        rdy_rand = 0;
        rdy_val = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
